det_timing_gen: RTL and testbench

DET_TIMING_GEN -- requirements
Module: det_timing_gen

---
 rtl/det_timing_gen.sv | 241 ++++++++++++++++++++++++
 tb/tb_det_timing_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/det_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : det_timing_gen
// Description : Detector frame timing generator. It sequences
//               IDLE -> ARM -> RUN -> STOP_PEND -> IDLE, produces the pixel
//               (ah) and line (av) counters, and counts completed frames.
//               It also manages a frame-synchronous exposure line with a
//               validated shadow register, and a one-frame correction flag.
//
// Ports       : clk        - single clock, rising edge
//               rst        - asynchronous active-high reset
//               start      - begin frame generation (from IDLE only)
//               stop       - end generation after the current frame
//               exp_in     - new exposure line value
//               exp_wr     - one-cycle write strobe for exp_in
//               korr_req   - request one correction frame
//               endet      - detector enable (RUN / STOP_PEND)
//               ah         - pixel-clock counter within the line
//               av         - line counter within the frame
//               iexp       - active exposure line, changes only at frame start
//               korr       - correction-frame flag
//               frame_cnt  - completed-frame counter (modulo 2^16)
//               exp_err    - one-cycle pulse after a rejected exp_wr
//               busy       - high whenever the FSM is not IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module det_timing_gen #(
  parameter int H_TOTAL = 1056,
  parameter int V_TOTAL = 1032,
  parameter int EXP_DEF = 512,
  parameter int ARM_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [10:0] exp_in,
  input  logic        exp_wr,
  input  logic        korr_req,
  output logic        endet,
  output logic [10:0] ah,
  output logic [10:0] av,
  output logic [10:0] iexp,
  output logic        korr,
  output logic [15:0] frame_cnt,
  output logic        exp_err,
  output logic        busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_ARM       = 2'd1;
  localparam logic [1:0] c_ST_RUN       = 2'd2;
  localparam logic [1:0] c_ST_STOP_PEND = 2'd3;

  localparam logic [10:0] c_H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_EXP_MAX  = 11'(V_TOTAL - 2);
  localparam logic [10:0] c_EXP_DEF  = 11'(EXP_DEF);
  localparam logic [15:0] c_ARM_LAST = 16'(ARM_CYC - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [15:0] r_arm_cnt;
  logic [10:0] r_ah;
  logic [10:0] r_av;
  logic [10:0] r_shadow;
  logic [10:0] r_iexp;
  logic        r_korr;
  logic        r_korr_pend;
  logic [15:0] r_frame_cnt;
  logic        r_exp_err;
  logic        r_busy;
  logic        r_endet;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [1:0] w_state_nxt;
  logic       w_running;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_fb;
  logic       w_start_go;
  logic       w_exp_ok;
  logic       w_stop_done;

  assign w_running   = (r_state == c_ST_RUN) || (r_state == c_ST_STOP_PEND);
  assign w_h_last    = (r_ah == c_H_LAST);
  assign w_v_last    = (r_av == c_V_LAST);
  // Frame boundary: the clock on which av wraps back to 0.
  assign w_fb        = w_running && w_h_last && w_v_last;
  // stop has priority over start while idle.
  assign w_start_go  = (r_state == c_ST_IDLE) && start && !stop;
  assign w_exp_ok    = (exp_in != 11'd0) && (exp_in <= c_EXP_MAX);
  assign w_stop_done = (r_state == c_ST_STOP_PEND) && w_fb;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_start_go) begin
          w_state_nxt = c_ST_ARM;
        end
      end
      c_ST_ARM: begin
        if (r_arm_cnt == c_ARM_LAST) begin
          w_state_nxt = c_ST_RUN;
        end
      end
      c_ST_RUN: begin
        if (stop) begin
          w_state_nxt = c_ST_STOP_PEND;
        end
      end
      c_ST_STOP_PEND: begin
        if (w_fb) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM and status flags. busy/endet are registered from the next state so
  // they line up exactly with the state they describe.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_busy    <= 1'b0;
      r_endet   <= 1'b0;
      r_arm_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != c_ST_IDLE);
      r_endet <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_STOP_PEND);
      if (w_start_go) begin
        r_arm_cnt <= 16'd0;
      end else if (r_state == c_ST_ARM) begin
        r_arm_cnt <= r_arm_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel / line counters and frame counter. Outside RUN/STOP_PEND the
  // counters are held at zero, so the first RUN cycle sees ah=av=0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ah        <= 11'd0;
      r_av        <= 11'd0;
      r_frame_cnt <= 16'd0;
    end else begin
      if (w_running) begin
        if (w_h_last) begin
          r_ah <= 11'd0;
          if (w_v_last) begin
            r_av <= 11'd0;
          end else begin
            r_av <= r_av + 11'd1;
          end
        end else begin
          r_ah <= r_ah + 11'd1;
        end
      end else begin
        r_ah <= 11'd0;
        r_av <= 11'd0;
      end
      if (w_fb) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Exposure shadow and active exposure. A write on the frame-boundary clock
  // lands in the shadow while iexp takes the old shadow value, so the new
  // value first applies one frame later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= c_EXP_DEF;
      r_iexp    <= c_EXP_DEF;
      r_exp_err <= 1'b0;
    end else begin
      r_exp_err <= exp_wr && !w_exp_ok;
      if (exp_wr && w_exp_ok) begin
        r_shadow <= exp_in;
      end
      if (w_fb || w_start_go) begin
        r_iexp <= r_shadow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Correction frame. A request is held in r_korr_pend and promoted to korr
  // at the next frame boundary; a request arriving on that same boundary
  // clock remains pending for the frame after. Finishing a stop clears both.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_korr      <= 1'b0;
      r_korr_pend <= 1'b0;
    end else begin
      if (w_stop_done) begin
        r_korr      <= 1'b0;
        r_korr_pend <= 1'b0;
      end else if (w_fb) begin
        r_korr      <= r_korr_pend;
        r_korr_pend <= korr_req;
      end else if (korr_req) begin
        r_korr_pend <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // --------------------------------------------------------------------------
  assign endet     = r_endet;
  assign ah        = r_ah;
  assign av        = r_av;
  assign iexp      = r_iexp;
  assign korr      = r_korr;
  assign frame_cnt = r_frame_cnt;
  assign exp_err   = r_exp_err;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_det_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_det_timing_gen
// Description : Self-checking bench for det_timing_gen with a reduced frame
//               geometry (132 x 8) so several frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_det_timing_gen;

  localparam int c_H = 132;
  localparam int c_V = 8;
  localparam int c_E = 5;
  localparam int c_A = 4;
  localparam int c_BUDGET = 2 * c_H * c_V + 50;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [10:0] exp_in;
  logic        exp_wr;
  logic        korr_req;
  logic        endet;
  logic [10:0] ah;
  logic [10:0] av;
  logic [10:0] iexp;
  logic        korr;
  logic [15:0] frame_cnt;
  logic        exp_err;
  logic        busy;

  int n_chk;
  int n_err;
  int exp_fc;

  typedef struct {
    logic [10:0] wr_val;
    logic        err;
    logic [10:0] iexp_after;
  } vec_t;

  vec_t tbl[6];

  det_timing_gen #(
    .H_TOTAL(c_H),
    .V_TOTAL(c_V),
    .EXP_DEF(c_E),
    .ARM_CYC(c_A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .exp_in   (exp_in),
    .exp_wr   (exp_wr),
    .korr_req (korr_req),
    .endet    (endet),
    .ah       (ah),
    .av       (av),
    .iexp     (iexp),
    .korr     (korr),
    .frame_cnt(frame_cnt),
    .exp_err  (exp_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Advance at least one cycle, then until ah/av reach the given position.
  task automatic wait_pos(input int a, input int v, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(ah == 11'(a) && av == 11'(v)) && n < c_BUDGET);
    n_chk++;
    if (!(ah == 11'(a) && av == 11'(v))) begin
      n_err++;
      $display("FAIL %s: timeout at ah=%0d av=%0d waiting for ah=%0d av=%0d",
               name, ah, av, a, v);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ah"}, 32'(ah), 0);
    chk({tag, "_av"}, 32'(av), 0);
    chk({tag, "_endet"}, 32'(endet), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_korr"}, 32'(korr), 0);
    chk({tag, "_fc"}, 32'(frame_cnt), 0);
    chk({tag, "_experr"}, 32'(exp_err), 0);
    chk({tag, "_iexp"}, 32'(iexp), c_E);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_fc = 0;

    // exposure write vectors: value, expected exp_err, iexp after next FB
    tbl[0] = '{wr_val: 11'd3,    err: 1'b0, iexp_after: 11'd3};
    tbl[1] = '{wr_val: 11'd0,    err: 1'b1, iexp_after: 11'd3};
    tbl[2] = '{wr_val: 11'd7,    err: 1'b1, iexp_after: 11'd3};
    tbl[3] = '{wr_val: 11'd6,    err: 1'b0, iexp_after: 11'd6};
    tbl[4] = '{wr_val: 11'd1,    err: 1'b0, iexp_after: 11'd1};
    tbl[5] = '{wr_val: 11'd2047, err: 1'b1, iexp_after: 11'd1};

    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    exp_in = 11'd0;
    exp_wr = 1'b0;
    korr_req = 1'b0;
    step();
    step();
    check_reset_vals("rst");
    rst = 1'b0;
    step();

    // start and stop together: stays idle
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", 32'(busy), 0);
    step();
    chk("startstop_busy2", 32'(busy), 0);

    // start: busy next cycle, endet after ARM_CYC cycles
    start = 1'b1;
    step();
    start = 1'b0;
    chk("arm_busy", 32'(busy), 1);
    chk("arm_endet", 32'(endet), 0);
    for (int i = 0; i < c_A - 1; i++) step();
    chk("arm_end_endet", 32'(endet), 0);
    chk("arm_end_ah", 32'(ah), 0);
    step();
    chk("run0_endet", 32'(endet), 1);
    chk("run0_ah", 32'(ah), 0);
    chk("run0_av", 32'(av), 0);
    step();
    chk("run1_ah", 32'(ah), 1);
    wait_pos(c_H - 1, 0, "wait_line0_end");
    step();
    chk("wrap_ah", 32'(ah), 0);
    chk("wrap_av", 32'(av), 1);

    // exposure write table
    for (int i = 0; i < 6; i++) begin
      logic [10:0] prev;
      prev = iexp;
      wait_pos(0, 2, "wait_expwr");
      exp_in = tbl[i].wr_val;
      exp_wr = 1'b1;
      step();
      exp_wr = 1'b0;
      chk($sformatf("experr_%0d", i), 32'(exp_err), 32'(tbl[i].err));
      step();
      chk($sformatf("experr_clr_%0d", i), 32'(exp_err), 0);
      chk($sformatf("iexp_mid_%0d", i), 32'(iexp), 32'(prev));
      wait_pos(c_H - 1, c_V - 1, "wait_frame_end");
      chk($sformatf("iexp_last_%0d", i), 32'(iexp), 32'(prev));
      step();
      exp_fc++;
      chk($sformatf("fb_ah_%0d", i), 32'(ah), 0);
      chk($sformatf("fb_av_%0d", i), 32'(av), 0);
      chk($sformatf("iexp_fb_%0d", i), 32'(iexp), 32'(tbl[i].iexp_after));
      chk($sformatf("fc_%0d", i), 32'(frame_cnt), 32'(exp_fc));
    end

    // exposure write on the frame-boundary clock
    wait_pos(c_H - 1, c_V - 1, "wait_coinc");
    exp_in = 11'd4;
    exp_wr = 1'b1;
    step();
    exp_wr = 1'b0;
    exp_fc++;
    chk("coinc_iexp_old", 32'(iexp), 1);
    chk("coinc_experr", 32'(exp_err), 0);
    chk("coinc_fc", 32'(frame_cnt), 32'(exp_fc));
    wait_pos(0, 0, "wait_coinc_fb2");
    exp_fc++;
    chk("coinc_iexp_new", 32'(iexp), 4);

    // correction frame
    wait_pos(0, 3, "wait_korr_req");
    korr_req = 1'b1;
    step();
    korr_req = 1'b0;
    chk("korr_not_yet", 32'(korr), 0);
    wait_pos(0, 0, "wait_korr_fb1");
    exp_fc++;
    chk("korr_on", 32'(korr), 1);
    wait_pos(0, 5, "wait_korr_mid");
    chk("korr_mid", 32'(korr), 1);
    wait_pos(0, 6, "wait_korr_req2");
    korr_req = 1'b1;
    step();
    korr_req = 1'b0;
    wait_pos(0, 0, "wait_korr_fb2");
    exp_fc++;
    chk("korr_again", 32'(korr), 1);
    wait_pos(0, 0, "wait_korr_fb3");
    exp_fc++;
    chk("korr_off", 32'(korr), 0);
    chk("korr_fc", 32'(frame_cnt), 32'(exp_fc));

    // stop mid-frame; start and korr_req during STOP_PEND
    wait_pos(0, 4, "wait_stop");
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_endet", 32'(endet), 1);
    chk("stop_busy", 32'(busy), 1);
    start = 1'b1;
    korr_req = 1'b1;
    step();
    start = 1'b0;
    korr_req = 1'b0;
    wait_pos(c_H - 1, c_V - 1, "wait_stop_end");
    chk("stop_last_endet", 32'(endet), 1);
    step();
    exp_fc++;
    chk("idle_endet", 32'(endet), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ah", 32'(ah), 0);
    chk("idle_av", 32'(av), 0);
    chk("idle_korr", 32'(korr), 0);
    chk("idle_fc", 32'(frame_cnt), 32'(exp_fc));
    for (int i = 0; i < 3; i++) step();
    chk("idle_stay_busy", 32'(busy), 0);
    chk("idle_stay_ah", 32'(ah), 0);

    // restart: frame_cnt kept, stale correction request discarded
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_fc", 32'(frame_cnt), 32'(exp_fc));
    wait_pos(1, 0, "wait_restart_run");
    wait_pos(0, 0, "wait_restart_fb");
    exp_fc++;
    chk("restart_fb_fc", 32'(frame_cnt), 32'(exp_fc));
    chk("restart_korr", 32'(korr), 0);
    chk("restart_iexp", 32'(iexp), 4);

    // asynchronous reset mid-frame
    wait_pos(0, 2, "wait_pre_rst");
    exp_in = 11'd2;
    exp_wr = 1'b1;
    korr_req = 1'b1;
    step();
    exp_wr = 1'b0;
    korr_req = 1'b0;
    wait_pos(7, 3, "wait_rst_point");
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("postrst_busy", 32'(busy), 0);
    chk("postrst_endet", 32'(endet), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pos(1, 0, "wait_rst_run");
    wait_pos(0, 0, "wait_rst_fb");
    chk("postrst_fc", 32'(frame_cnt), 1);
    chk("postrst_iexp", 32'(iexp), c_E);
    chk("postrst_korr", 32'(korr), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
